// File: rtl/calc_result_display.sv
// Latches a calculator result on a Done rising edge, converts it to BCD by double-dabble and scans it onto eight 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 4..1.
module calc_result_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] C,
  input  logic        Flag,
  input  logic        Done,
  input  logic        QErr,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, SHOW = 2'd2} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b1111010;

  state_t                  r_state;
  logic                    r_done;
  logic [15:0]             r_c;
  logic                    r_flag;
  logic                    r_qerr;
  logic [19:0]             r_bcd;
  logic [3:0]              r_step;
  logic                    r_busy;
  logic [REFRESH_BITS-1:0] r_cnt;
  logic                    r_vld;
  logic [19:0]             r_sbcd;
  logic                    r_sflag;
  logic                    r_serr;
  logic [7:0]              r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_cap;
  logic                    w_last;
  logic [19:0]             w_adj;
  logic [19:0]             w_bcd_step;
  logic                    w_vld_n;
  logic [19:0]             w_sbcd_n;
  logic                    w_sflag_n;
  logic                    w_serr_n;
  logic [REFRESH_BITS-1:0] w_cnt_n;
  logic [2:0]              w_k;
  logic [3:0]              w_nib;
  logic [7:0]              w_lz;
  logic [6:0]              w_seg_n;
  logic                    w_dp_n;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'b0000001;
      4'd1:    f_seg = 7'b1001111;
      4'd2:    f_seg = 7'b0010010;
      4'd3:    f_seg = 7'b0000110;
      4'd4:    f_seg = 7'b1001100;
      4'd5:    f_seg = 7'b0100100;
      4'd6:    f_seg = 7'b0100000;
      4'd7:    f_seg = 7'b0001111;
      4'd8:    f_seg = 7'b0000000;
      4'd9:    f_seg = 7'b0000100;
      default: f_seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [19:0] f_adjust(input logic [19:0] b);
    f_adjust = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) f_adjust[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
  endfunction

  assign w_cap      = Done & ~r_done;
  assign w_last     = (r_state == CONVERT) && (r_step == 4'd15);
  assign w_adj      = f_adjust(r_bcd);
  assign w_bcd_step = {w_adj[18:0], r_c[15]};

  // Outputs are registered from next-cycle values so they line up with the state they describe.
  assign w_vld_n   = w_last | r_vld;
  assign w_sbcd_n  = w_last ? w_bcd_step : r_sbcd;
  assign w_sflag_n = w_last ? r_flag : r_sflag;
  assign w_serr_n  = w_last ? r_qerr : r_serr;
  assign w_cnt_n   = r_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
  assign w_k       = w_cnt_n[REFRESH_BITS-1 -: 3];

  always_comb begin
    w_lz = 8'd0;
`ifdef LEADING_ZERO_BLANK_EN
    w_lz[4] = (w_sbcd_n[19:16] == 4'd0);
    w_lz[3] = w_lz[4] & (w_sbcd_n[15:12] == 4'd0);
    w_lz[2] = w_lz[3] & (w_sbcd_n[11:8] == 4'd0);
    w_lz[1] = w_lz[2] & (w_sbcd_n[7:4] == 4'd0);
`endif
  end

  always_comb begin
    w_nib = 4'd0;
    case (w_k)
      3'd0:    w_nib = w_sbcd_n[3:0];
      3'd1:    w_nib = w_sbcd_n[7:4];
      3'd2:    w_nib = w_sbcd_n[11:8];
      3'd3:    w_nib = w_sbcd_n[15:12];
      3'd4:    w_nib = w_sbcd_n[19:16];
      default: w_nib = 4'd0;
    endcase
  end

  always_comb begin
    w_seg_n = SEG_BLANK;
    w_dp_n  = 1'b1;
    if (w_vld_n) begin
      if (w_serr_n) begin
        if (w_k == 3'd2) w_seg_n = SEG_E;
        else if (w_k < 3'd2) w_seg_n = SEG_R;
      end else if (w_k < 3'd5) begin
        w_seg_n = w_lz[w_k] ? SEG_BLANK : f_seg(w_nib);
        w_dp_n  = ~((w_k == 3'd0) & w_sflag_n);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_c     <= 16'd0;
      r_flag  <= 1'b0;
      r_qerr  <= 1'b0;
      r_bcd   <= 20'd0;
      r_step  <= 4'd0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_sbcd  <= 20'd0;
      r_sflag <= 1'b0;
      r_serr  <= 1'b0;
      r_an    <= 8'b11111110;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_done  <= Done;
      r_cnt   <= w_cnt_n;
      r_vld   <= w_vld_n;
      r_sbcd  <= w_sbcd_n;
      r_sflag <= w_sflag_n;
      r_serr  <= w_serr_n;
      r_an    <= ~(8'd1 << w_k);
      r_seg   <= w_seg_n;
      r_dp    <= w_dp_n;
      case (r_state)
        IDLE, SHOW: begin
          if (w_cap) begin
            r_c     <= C;
            r_flag  <= Flag;
            r_qerr  <= QErr;
            r_bcd   <= 20'd0;
            r_step  <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_bcd  <= w_bcd_step;
          r_c    <= {r_c[14:0], 1'b0};
          r_step <= r_step + 4'd1;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_state <= SHOW;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign An   = r_an;
  assign Seg  = r_seg;
  assign Dp   = r_dp;
  assign Busy = r_busy;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed bench for calc_result_display: conversion latency, digit scan contents, error/overflow display, reset abort.
module tb_calc_result_display;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] C;
  logic        Flag;
  logic        Done;
  logic        QErr;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  logic [5:0] m_cnt;
  logic [6:0] exp_seg[8];
  logic       exp_dp[8];

  always #5 Clk = ~Clk;

  calc_result_display #(.REFRESH_BITS(6)) dut (
    .Clk(Clk), .Reset(Reset), .C(C), .Flag(Flag), .Done(Done), .QErr(QErr),
    .An(An), .Seg(Seg), .Dp(Dp), .Busy(Busy)
  );

  // Scan position reference: counts clock edges since the last reset edge.
  always @(posedge Clk) begin
    if (Reset) m_cnt <= 6'd0;
    else       m_cnt <= m_cnt + 6'd1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b0000001;
      1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;
      3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;
      5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;
      7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0000100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_now(input string tag);
    logic [2:0] k;
    logic [7:0] ea;
    k  = m_cnt[5:3];
    ea = ~(8'd1 << k);
    chk({tag, "_an"}, {24'd0, An}, {24'd0, ea});
    chk({tag, "_seg"}, {25'd0, Seg}, {25'd0, exp_seg[k]});
    chk({tag, "_dp"}, {31'd0, Dp}, {31'd0, exp_dp[k]});
  endtask

  task automatic set_blank();
    for (int i = 0; i < 8; i++) begin
      exp_seg[i] = 7'b1111111;
      exp_dp[i]  = 1'b1;
    end
  endtask

  task automatic set_num(input int v, input bit f);
    int p;
    set_blank();
    p = 1;
    for (int i = 0; i < 5; i++) begin
      exp_seg[i] = seg_of((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) exp_seg[i] = 7'b1111111;
`endif
      p = p * 10;
    end
    exp_dp[0] = ~f;
  endtask

  task automatic set_err();
    set_blank();
    exp_seg[2] = 7'b0110000;
    exp_seg[1] = 7'b1111010;
    exp_seg[0] = 7'b1111010;
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 64; i++) begin
      check_now(tag);
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
      @(negedge Clk);
    end
  endtask

  task automatic busy_phase(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      check_now({tag, "_old"});
    end
  endtask

  task automatic start(input logic [15:0] c, input logic f, input logic q);
    C    = c;
    Flag = f;
    QErr = q;
    Done = 1'b1;
  endtask

  initial begin
    Reset = 1'b1;
    C     = 16'd0;
    Flag  = 1'b0;
    Done  = 1'b0;
    QErr  = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_an", {24'd0, An}, 32'hFE);
    chk("rst_seg", {25'd0, Seg}, 32'h7F);
    chk("rst_dp", {31'd0, Dp}, 32'd1);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;
    set_blank();
    scan("idle");

    // 12345: one-cycle Done pulse, 16 busy cycles, then digits.
    start(16'd12345, 1'b0, 1'b0);
    busy_phase("c12345", 1);
    Done = 1'b0;
    busy_phase("c12345", 15);
    @(negedge Clk);
    chk("c12345_end_busy", {31'd0, Busy}, 32'd0);
    set_num(12345, 1'b0);
    scan("c12345");

    // 65535 with overflow; a second Done edge mid-conversion must be ignored.
    start(16'd65535, 1'b1, 1'b0);
    busy_phase("c65535", 1);
    Done = 1'b0;
    busy_phase("c65535", 4);
    Done = 1'b1;
    C    = 16'd1;
    busy_phase("c65535", 1);
    Done = 1'b0;
    busy_phase("c65535", 10);
    @(negedge Clk);
    chk("c65535_end_busy", {31'd0, Busy}, 32'd0);
    set_num(65535, 1'b1);
    scan("c65535");

    // 7: leading-zero handling depends on the build.
    start(16'd7, 1'b0, 1'b0);
    busy_phase("c7", 1);
    Done = 1'b0;
    busy_phase("c7", 15);
    @(negedge Clk);
    set_num(7, 1'b0);
    scan("c7");

    // Error display overrides value and overflow.
    start(16'd999, 1'b1, 1'b1);
    busy_phase("err", 1);
    Done = 1'b0;
    busy_phase("err", 15);
    @(negedge Clk);
    set_err();
    scan("err");

    // Reset in the 8th conversion cycle; Done held through reset recaptures.
    start(16'd4096, 1'b0, 1'b0);
    busy_phase("abort", 8);
    Reset = 1'b1;
    C     = 16'd4097;
    @(negedge Clk);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    set_blank();
    check_now("abort");
    Reset = 1'b0;
    busy_phase("recap", 16);
    @(negedge Clk);
    chk("recap_end_busy", {31'd0, Busy}, 32'd0);
    set_num(4097, 1'b0);
    scan("recap");
    C = 16'd1;
    scan("hold");
    Done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
